// File: rtl/elevator_scheduler_if.sv
// Button, step-handshake and status bundle between the elevator scheduler and the car datapath.
interface elevator_scheduler_if #(
  parameter int FLOORS = 3
);
  localparam int FW = $clog2(FLOORS);

  logic [FLOORS-1:0] car_req;
  logic [FLOORS-1:0] hall_req;
  logic              step_done;
  logic              step_req;
  logic              step_dir;
  logic [1:0]        engine;
  logic [FLOORS-1:0] doors;
  logic [FW-1:0]     cur_floor;
  logic [FLOORS-1:0] pending;
  logic              direction;

  modport master (
    input  car_req, hall_req, step_done,
    output step_req, step_dir, engine, doors, cur_floor, pending, direction
  );

  modport slave (
    output car_req, hall_req, step_done,
    input  step_req, step_dir, engine, doors, cur_floor, pending, direction
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Collective (SCAN) elevator request scheduler: latches buttons, steps the car one floor
// at a time over a req/done handshake and times the door dwell.
module elevator_scheduler #(
  parameter int FLOORS      = 3,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RST,
  elevator_scheduler_if.master bus
);
  localparam int FW = $clog2(FLOORS);
  localparam int CW = $clog2(DOOR_CYCLES);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);
  localparam logic [FW-1:0] FLOOR_ONE = FW'(1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     cur_floor_q, cur_floor_d;
  logic              direction_q, direction_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [FLOORS-1:0] btn_s;
  logic [FLOORS-1:0] pend_all_s;
  logic [FW-1:0]     next_floor_s;

  function automatic logic [FLOORS-1:0] floor_bit(input logic [FW-1:0] f);
    floor_bit = {{(FLOORS-1){1'b0}}, 1'b1} << f;
  endfunction

  // Any request strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic any_toward(input logic [FLOORS-1:0] pend,
                                      input logic [FW-1:0]     f,
                                      input logic              up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pend[i] && (up ? (i > int'(f)) : (i < int'(f)))) r = 1'b1;
    end
    return r;
  endfunction

  // The end floors admit only one travel direction.
  function automatic logic sweep_dir(input logic [FW-1:0] f, input logic want_up);
    if (f == {FW{1'b0}})    sweep_dir = 1'b1;
    else if (f == TOP_FLOOR) sweep_dir = 1'b0;
    else                     sweep_dir = want_up;
  endfunction

  // State and datapath registers, cleared asynchronously by RST.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cur_floor_q <= {FW{1'b0}};
      direction_q <= 1'b1;
      pending_q   <= {FLOORS{1'b0}};
      cnt_q       <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      direction_q <= direction_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state: IDLE looks at latched requests only; stop decisions also see this cycle's buttons.
  always_comb begin
    state_d      = state_q;
    cur_floor_d  = cur_floor_q;
    direction_d  = direction_q;
    cnt_d        = cnt_q;
    btn_s        = bus.car_req | bus.hall_req;
    pend_all_s   = pending_q | btn_s;
    next_floor_s = cur_floor_q;
    case (state_q)
      IDLE: begin
        if (pending_q[cur_floor_q]) begin
          state_d = DOOR_OPEN;
          cnt_d   = CNT_LOAD;
        end else if (any_toward(pending_q, cur_floor_q, direction_q)) begin
          state_d     = MOVE;
          direction_d = sweep_dir(cur_floor_q, direction_q);
        end else if (any_toward(pending_q, cur_floor_q, ~direction_q)) begin
          state_d     = MOVE;
          direction_d = sweep_dir(cur_floor_q, ~direction_q);
        end else begin
          state_d = IDLE;
        end
      end
      MOVE: begin
        // A step that would leave the shaft is dropped.
        if (bus.step_done && !(direction_q ? (cur_floor_q == TOP_FLOOR)
                                           : (cur_floor_q == {FW{1'b0}}))) begin
          next_floor_s = direction_q ? (cur_floor_q + FLOOR_ONE) : (cur_floor_q - FLOOR_ONE);
          cur_floor_d  = next_floor_s;
          if (pend_all_s[next_floor_s]) begin
            state_d = DOOR_OPEN;
            cnt_d   = CNT_LOAD;
          end else if (any_toward(pend_all_s, next_floor_s, direction_q)) begin
            state_d = MOVE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = MOVE;
        end
      end
      DOOR_OPEN: begin
        if (btn_s[cur_floor_q]) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == {CW{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d == DOOR_OPEN) begin
      pending_d = pend_all_s & ~floor_bit(cur_floor_d);
    end else begin
      pending_d = pend_all_s;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.step_req  = 1'b0;
    bus.step_dir  = direction_q;
    bus.engine    = 2'b00;
    bus.doors     = {FLOORS{1'b0}};
    bus.cur_floor = cur_floor_q;
    bus.pending   = pending_q;
    bus.direction = direction_q;
    case (state_q)
      MOVE: begin
        bus.step_req = 1'b1;
        bus.engine   = {1'b1, ~direction_q};
      end
      DOOR_OPEN: begin
        bus.doors = floor_bit(cur_floor_q);
      end
      default: begin
        bus.step_req = 1'b0;
      end
    endcase
  end
endmodule
